// File: rtl/intg_pkg.sv
// Shared widths, default threshold and result-entry layout for the window
// integrator consumer path.
package intg_pkg;
    localparam int SUM_W      = 13;
    localparam int WIN_LOG2   = 2;
    localparam int AVG_W      = SUM_W - WIN_LOG2;
    localparam int THRESH_DEF = 200;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic             over;
        logic [AVG_W-1:0] avg;
    } intg_entry_t;
endpackage

// File: rtl/intg_sync_fifo.sv
// Generic show-ahead synchronous FIFO: the head entry is visible on o_rdata
// whenever the FIFO is non-empty, zero otherwise.
module intg_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/intg_window_fifo.sv
// Scales each window sum to a per-sample average, flags it against THRESH and
// buffers {over, avg}. Optional peak-hold register under INTG_PEAK_HOLD_EN.
module intg_window_fifo
    import intg_pkg::*;
#(
    parameter int SUM_W    = intg_pkg::SUM_W,
    parameter int WIN_LOG2 = intg_pkg::WIN_LOG2,
    parameter int DEPTH    = intg_pkg::DEPTH_DEF,
    parameter int THRESH   = intg_pkg::THRESH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SUM_W-1:0]            sum_in,
    input  logic                        sum_vld,
    output logic [SUM_W-WIN_LOG2:0]     out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        ovf
`ifdef INTG_PEAK_HOLD_EN
   ,output logic [SUM_W-WIN_LOG2-1:0]   peak_avg,
    input  logic                        peak_clr
`endif
);
    localparam int AVG_LW = SUM_W - WIN_LOG2;

    logic [AVG_LW-1:0] w_avg;
    logic              w_over;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_unused_lsb;
    logic              r_ovf;

    // Truncating divide by the window length; the low bits are discarded.
    assign w_avg        = sum_in[SUM_W-1:WIN_LOG2];
    assign w_unused_lsb = ^sum_in[WIN_LOG2-1:0];
    assign w_over       = (w_avg >= AVG_LW'(THRESH));

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = sum_vld & (~w_full | w_pop);
    assign w_drop    = sum_vld & w_full & ~w_pop;
    assign ovf       = r_ovf;

    intg_sync_fifo #(
        .WIDTH (AVG_LW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (sum_vld),
        .i_wdata ({w_over, w_avg}),
        .i_pop   (out_ready),
        .o_rdata (out_data),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

`ifdef INTG_PEAK_HOLD_EN
    logic [AVG_LW-1:0] r_peak_avg;

    assign peak_avg = r_peak_avg;

    // A clear that coincides with a push restarts the peak from that push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak_avg <= '0;
        end else if (peak_clr) begin
            r_peak_avg <= w_push ? w_avg : '0;
        end else if (w_push && (w_avg > r_peak_avg)) begin
            r_peak_avg <= w_avg;
        end
    end
`endif
endmodule
